// File: rtl/czono_pkg.sv
// Shared types, default sizes and dimension rules for the CZonotope schedulers.
package czono_pkg;

   localparam int unsigned NREQ_DEF    = 2;
   localparam int unsigned NBANK_DEF   = 4;
   localparam int unsigned NMAX_DEF    = 3;
   localparam int unsigned NGMAX_DEF   = 15;
   localparam int unsigned NCMAX_DEF   = 12;
   localparam int unsigned TIMEOUT_DEF = 1024;

   localparam int unsigned BANK_W = $clog2(NBANK_DEF);
   localparam int unsigned N_W    = $clog2(NMAX_DEF);
   localparam int unsigned NG_W   = $clog2(NGMAX_DEF);
   localparam int unsigned NC_W   = $clog2(NCMAX_DEF);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_START,
      S_RUN,
      S_WB,
      S_DONE
   } state_e;

   // Minkowski sum needs equal state dimension and summed sizes within limits.
   function automatic logic plus_dims_ok(input int unsigned zn, input int unsigned wn,
                                         input int unsigned ng_sum, input int unsigned nc_sum,
                                         input int unsigned ngmax, input int unsigned ncmax);
      return (zn == wn) && (ng_sum <= ngmax) && (nc_sum <= ncmax);
   endfunction

endpackage

// File: rtl/czono_plus_sched_if.sv
// Requester, bank-dimension and engine signals of the plus scheduler.
interface czono_plus_sched_if import czono_pkg::*; #(
   parameter int unsigned NREQ  = NREQ_DEF,
   parameter int unsigned NBANK = NBANK_DEF,
   parameter int unsigned NMAX  = NMAX_DEF,
   parameter int unsigned NGMAX = NGMAX_DEF,
   parameter int unsigned NCMAX = NCMAX_DEF
);
   localparam int unsigned BW  = $clog2(NBANK);
   localparam int unsigned NW  = $clog2(NMAX);
   localparam int unsigned NGW = $clog2(NGMAX);
   localparam int unsigned NCW = $clog2(NCMAX);

   logic [NREQ-1:0]       req_i;
   logic [NREQ*BW-1:0]    req_z_i;
   logic [NREQ*BW-1:0]    req_w_i;
   logic [NREQ*BW-1:0]    req_out_i;
   logic [NREQ-1:0]       done_o;
   logic [NREQ-1:0]       err_o;
   logic [NBANK*NW-1:0]   bank_n_i;
   logic [NBANK*NGW-1:0]  bank_ng_i;
   logic [NBANK*NCW-1:0]  bank_nc_i;
   logic                  eng_rstn_o;
   logic                  eng_valid_i;
   logic [BW-1:0]         z_sel_o;
   logic [BW-1:0]         w_sel_o;
   logic [BW-1:0]         out_sel_o;
   logic                  dim_we_o;
   logic [BW-1:0]         dim_bank_o;
   logic [NW-1:0]         dim_n_o;
   logic [NGW-1:0]        dim_ng_o;
   logic [NCW-1:0]        dim_nc_o;
   logic                  busy_o;

   modport slave (
      input  req_i, req_z_i, req_w_i, req_out_i, bank_n_i, bank_ng_i, bank_nc_i, eng_valid_i,
      output done_o, err_o, eng_rstn_o, z_sel_o, w_sel_o, out_sel_o,
             dim_we_o, dim_bank_o, dim_n_o, dim_ng_o, dim_nc_o, busy_o
   );

   modport master (
      output req_i, req_z_i, req_w_i, req_out_i, bank_n_i, bank_ng_i, bank_nc_i, eng_valid_i,
      input  done_o, err_o, eng_rstn_o, z_sel_o, w_sel_o, out_sel_o,
             dim_we_o, dim_bank_o, dim_n_o, dim_ng_o, dim_nc_o, busy_o
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr_i wins.
module rr_arbiter #(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [$clog2(NREQ)-1:0] idx_o
);
   localparam int unsigned IW = $clog2(NREQ);

   always_comb begin
      int unsigned cand;
      logic        found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = (32'(ptr_i) + i) % NREQ;
         if (!found && req_i[IW'(cand)]) begin
            found              = 1'b1;
            gnt_o[IW'(cand)]   = 1'b1;
            idx_o              = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/czono_plus_sched.sv
// Shares one CZonotope plus engine between NREQ requesters: arbitrate, check
// dimensions, run the engine under a timeout, write back OUT dims, acknowledge.
module czono_plus_sched import czono_pkg::*; #(
   parameter int unsigned NREQ    = NREQ_DEF,
   parameter int unsigned NBANK   = NBANK_DEF,
   parameter int unsigned NMAX    = NMAX_DEF,
   parameter int unsigned NGMAX   = NGMAX_DEF,
   parameter int unsigned NCMAX   = NCMAX_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   czono_plus_sched_if.slave     bus
);
   localparam int unsigned BW  = $clog2(NBANK);
   localparam int unsigned NW  = $clog2(NMAX);
   localparam int unsigned NGW = $clog2(NGMAX);
   localparam int unsigned NCW = $clog2(NCMAX);
   localparam int unsigned IW  = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(TIMEOUT);

   state_e          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   win_q, win_d;
   logic [BW-1:0]   z_q, z_d, w_q, w_d, out_q, out_d;
   logic [NW-1:0]   zn_q, zn_d, wn_q, wn_d;
   logic [NGW-1:0]  zng_q, zng_d, wng_q, wng_d;
   logic [NCW-1:0]  znc_q, znc_d, wnc_q, wnc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;

   logic [NREQ-1:0] arb_gnt;
   logic [IW-1:0]   arb_idx;
   logic [BW-1:0]   g_z, g_w, g_out;
   logic [NGW:0]    ng_sum;
   logic [NCW:0]    nc_sum;
   logic            bank_bad;
   logic            chk_err;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i (bus.req_i),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   assign g_z   = bus.req_z_i[arb_idx*BW +: BW];
   assign g_w   = bus.req_w_i[arb_idx*BW +: BW];
   assign g_out = bus.req_out_i[arb_idx*BW +: BW];

   // One bit wider than the fields so an oversized sum cannot wrap past the check.
   assign ng_sum = {1'b0, zng_q} + {1'b0, wng_q};
   assign nc_sum = {1'b0, znc_q} + {1'b0, wnc_q};

   if ((1 << BW) > NBANK) begin : g_bank_chk
      assign bank_bad = (z_q >= BW'(NBANK)) || (w_q >= BW'(NBANK)) || (out_q >= BW'(NBANK));
   end else begin : g_no_bank_chk
      assign bank_bad = 1'b0;
   end

   assign chk_err = !plus_dims_ok(32'(zn_q), 32'(wn_q), 32'(ng_sum), 32'(nc_sum), NGMAX, NCMAX)
                    || (out_q == z_q) || (out_q == w_q) || bank_bad;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         z_q     <= '0;
         w_q     <= '0;
         out_q   <= '0;
         zn_q    <= '0;
         wn_q    <= '0;
         zng_q   <= '0;
         wng_q   <= '0;
         znc_q   <= '0;
         wnc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         z_q     <= z_d;
         w_q     <= w_d;
         out_q   <= out_d;
         zn_q    <= zn_d;
         wn_q    <= wn_d;
         zng_q   <= zng_d;
         wng_q   <= wng_d;
         znc_q   <= znc_d;
         wnc_q   <= wnc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      z_d     = z_q;
      w_d     = w_q;
      out_d   = out_q;
      zn_d    = zn_q;
      wn_d    = wn_q;
      zng_d   = zng_q;
      wng_d   = wng_q;
      znc_d   = znc_q;
      wnc_d   = wnc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (|arb_gnt) begin
               state_d = S_CHECK;
               win_d   = arb_idx;
               ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
               z_d     = g_z;
               w_d     = g_w;
               out_d   = g_out;
               zn_d    = bus.bank_n_i[g_z*NW +: NW];
               wn_d    = bus.bank_n_i[g_w*NW +: NW];
               zng_d   = bus.bank_ng_i[g_z*NGW +: NGW];
               wng_d   = bus.bank_ng_i[g_w*NGW +: NGW];
               znc_d   = bus.bank_nc_i[g_z*NCW +: NCW];
               wnc_d   = bus.bank_nc_i[g_w*NCW +: NCW];
            end
         end
         S_CHECK: begin
            if (chk_err) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            // Engine output is still the registered reset value in the first RUN cycle.
            if ((cnt_q != '0) && bus.eng_valid_i) begin
               state_d = S_WB;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WB: state_d = S_DONE;
         S_DONE: begin
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.eng_rstn_o = 1'b0;
      bus.done_o     = '0;
      bus.err_o      = '0;
      bus.dim_we_o   = 1'b0;
      bus.busy_o     = 1'b1;
      unique case (state_q)
         S_IDLE:  bus.busy_o     = 1'b0;
         S_RUN:   bus.eng_rstn_o = 1'b1;
         S_WB:    bus.dim_we_o   = 1'b1;
         S_DONE: begin
            bus.done_o[win_q] = 1'b1;
            bus.err_o[win_q]  = err_q;
         end
         default: ;
      endcase
      bus.z_sel_o    = z_q;
      bus.w_sel_o    = w_q;
      bus.out_sel_o  = out_q;
      bus.dim_bank_o = out_q;
      bus.dim_n_o    = zn_q;
      bus.dim_ng_o   = ng_sum[NGW-1:0];
      bus.dim_nc_o   = nc_sum[NCW-1:0];
   end

endmodule

// File: tb/tb_czono_plus_sched.sv
// Directed bench for czono_plus_sched: legal job, check errors, arbitration, timeout, reset.
module tb_czono_plus_sched;
   import czono_pkg::*;

   logic clk;
   logic rstn;
   int   checks = 0;
   int   errors = 0;

   czono_plus_sched_if #(.NREQ(2), .NBANK(4), .NMAX(3), .NGMAX(15), .NCMAX(12)) bus ();

   czono_plus_sched #(.NREQ(2), .NBANK(4), .NMAX(3), .NGMAX(15), .NCMAX(12), .TIMEOUT(1024)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_bank(input int b, input logic [N_W-1:0] n, input logic [NG_W-1:0] ng,
                           input logic [NC_W-1:0] nc);
      bus.bank_n_i[b*N_W +: N_W]    = n;
      bus.bank_ng_i[b*NG_W +: NG_W] = ng;
      bus.bank_nc_i[b*NC_W +: NC_W] = nc;
   endtask

   task automatic set_req(input int r, input logic [BANK_W-1:0] z, input logic [BANK_W-1:0] w,
                          input logic [BANK_W-1:0] o);
      bus.req_z_i[r*BANK_W +: BANK_W]   = z;
      bus.req_w_i[r*BANK_W +: BANK_W]   = w;
      bus.req_out_i[r*BANK_W +: BANK_W] = o;
   endtask

   // Job expected to pass CHECK: wait for RUN, give valid after vdelay, check WB and DONE.
   task automatic run_job(input string tag, input int vdelay, input logic [1:0] exp_done,
                          input logic [1:0] exp_bank, input logic [1:0] exp_n,
                          input logic [3:0] exp_ng, input logic [3:0] exp_nc);
      int k;
      k = 0;
      while (bus.eng_rstn_o !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_run"}, 32'(bus.eng_rstn_o), 1);
      repeat (vdelay) @(negedge clk);
      bus.eng_valid_i = 1'b1;
      @(negedge clk);
      bus.eng_valid_i = 1'b0;
      chk({tag, "_we"},   32'(bus.dim_we_o), 1);
      chk({tag, "_bank"}, 32'(bus.dim_bank_o), 32'(exp_bank));
      chk({tag, "_n"},    32'(bus.dim_n_o), 32'(exp_n));
      chk({tag, "_ng"},   32'(bus.dim_ng_o), 32'(exp_ng));
      chk({tag, "_nc"},   32'(bus.dim_nc_o), 32'(exp_nc));
      chk({tag, "_wbrst"}, 32'(bus.eng_rstn_o), 0);
      @(negedge clk);
      chk({tag, "_done"}, 32'(bus.done_o), 32'(exp_done));
      chk({tag, "_err"},  32'(bus.err_o), 0);
   endtask

   // Job expected to fail CHECK: done/err two cycles after the request, engine untouched.
   task automatic err_job(input string tag, input logic [1:0] exp);
      @(negedge clk);
      chk({tag, "_busy"},  32'(bus.busy_o), 1);
      chk({tag, "_early"}, 32'(bus.done_o), 0);
      @(negedge clk);
      chk({tag, "_done"}, 32'(bus.done_o), 32'(exp));
      chk({tag, "_err"},  32'(bus.err_o), 32'(exp));
      chk({tag, "_rst"},  32'(bus.eng_rstn_o), 0);
      chk({tag, "_we"},   32'(bus.dim_we_o), 0);
   endtask

   initial begin
      int   n;
      logic seen_we, last_rstn, seen_done;

      rstn            = 1'b1;
      bus.req_i       = '0;
      bus.req_z_i     = '0;
      bus.req_w_i     = '0;
      bus.req_out_i   = '0;
      bus.bank_n_i    = '0;
      bus.bank_ng_i   = '0;
      bus.bank_nc_i   = '0;
      bus.eng_valid_i = 1'b0;
      #1 rstn = 1'b0;
      #1;
      chk("rst_engrst", 32'(bus.eng_rstn_o), 0);
      chk("rst_busy",   32'(bus.busy_o), 0);
      chk("rst_done",   32'(bus.done_o), 0);
      chk("rst_err",    32'(bus.err_o), 0);
      chk("rst_we",     32'(bus.dim_we_o), 0);
      chk("rst_zsel",   32'(bus.z_sel_o), 0);
      chk("rst_osel",   32'(bus.out_sel_o), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // Single legal job with exact cycle timing.
      set_bank(0, 2, 3, 1);
      set_bank(1, 2, 4, 2);
      set_req(0, 0, 1, 2);
      bus.req_i = 2'b01;
      @(negedge clk);
      chk("t1_busy",  32'(bus.busy_o), 1);
      chk("t1_chk_rst", 32'(bus.eng_rstn_o), 0);
      chk("t1_zsel",  32'(bus.z_sel_o), 0);
      chk("t1_wsel",  32'(bus.w_sel_o), 1);
      chk("t1_osel",  32'(bus.out_sel_o), 2);
      @(negedge clk);
      chk("t1_start_rst", 32'(bus.eng_rstn_o), 0);
      @(negedge clk);
      chk("t1_run_rst", 32'(bus.eng_rstn_o), 1);
      bus.eng_valid_i = 1'b1;
      @(negedge clk);
      bus.eng_valid_i = 1'b0;
      chk("t1_ignore_rst", 32'(bus.eng_rstn_o), 1);
      chk("t1_ignore_we",  32'(bus.dim_we_o), 0);
      repeat (36) @(negedge clk);
      chk("t1_wsel_hold", 32'(bus.w_sel_o), 1);
      bus.eng_valid_i = 1'b1;
      @(negedge clk);
      bus.eng_valid_i = 1'b0;
      chk("t1_we",    32'(bus.dim_we_o), 1);
      chk("t1_bank",  32'(bus.dim_bank_o), 2);
      chk("t1_n",     32'(bus.dim_n_o), 2);
      chk("t1_ng",    32'(bus.dim_ng_o), 7);
      chk("t1_nc",    32'(bus.dim_nc_o), 3);
      chk("t1_wb_rst", 32'(bus.eng_rstn_o), 0);
      chk("t1_wb_done", 32'(bus.done_o), 0);
      @(negedge clk);
      chk("t1_done",  32'(bus.done_o), 1);
      chk("t1_err",   32'(bus.err_o), 0);
      chk("t1_we_off", 32'(bus.dim_we_o), 0);
      bus.req_i = 2'b00;
      @(negedge clk);
      chk("t1_idle",  32'(bus.busy_o), 0);
      chk("t1_pulse", 32'(bus.done_o), 0);

      // Generator sum 16 exceeds 15.
      set_bank(0, 2, 8, 1);
      set_bank(1, 2, 8, 1);
      bus.req_i = 2'b01;
      err_job("ngsum", 2'b01);
      bus.req_i = 2'b00;
      @(negedge clk);

      // Constraint sum 13 exceeds 12.
      set_bank(0, 2, 1, 6);
      set_bank(1, 2, 1, 7);
      bus.req_i = 2'b01;
      err_job("ncsum", 2'b01);
      bus.req_i = 2'b00;
      @(negedge clk);

      // OUT aliases Z on requester 1.
      set_bank(0, 2, 1, 1);
      set_bank(1, 2, 1, 1);
      set_req(1, 1, 0, 1);
      bus.req_i = 2'b10;
      err_job("alias_z", 2'b10);
      bus.req_i = 2'b00;
      @(negedge clk);

      // OUT aliases W.
      set_req(0, 0, 1, 1);
      bus.req_i = 2'b01;
      err_job("alias_w", 2'b01);
      bus.req_i = 2'b00;
      @(negedge clk);

      // State dimension mismatch.
      set_bank(1, 3, 1, 1);
      set_req(0, 0, 1, 2);
      bus.req_i = 2'b01;
      err_job("nmis", 2'b01);
      bus.req_i = 2'b00;
      @(negedge clk);

      // Both requesting continuously; pointer is 1 after the last grant to 0.
      set_bank(0, 2, 7, 5);
      set_bank(1, 2, 8, 7);
      set_bank(2, 1, 1, 1);
      set_bank(3, 1, 2, 3);
      set_req(0, 0, 1, 2);
      set_req(1, 2, 3, 0);
      bus.req_i = 2'b11;
      run_job("arb1", 2, 2'b10, 0, 1, 3, 4);
      run_job("arb2", 3, 2'b01, 2, 2, 15, 12);
      run_job("arb3", 1, 2'b10, 0, 1, 3, 4);
      run_job("arb4", 4, 2'b01, 2, 2, 15, 12);
      bus.req_i = 2'b00;
      @(negedge clk);

      // Engine never answers.
      bus.req_i = 2'b01;
      n = 0;
      while (bus.eng_rstn_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("to_run", 32'(bus.eng_rstn_o), 1);
      n         = 0;
      seen_we   = 1'b0;
      last_rstn = 1'b0;
      while (bus.done_o === 2'b00 && n < 1100) begin
         last_rstn = bus.eng_rstn_o;
         @(negedge clk);
         n++;
         if (bus.dim_we_o === 1'b1) seen_we = 1'b1;
      end
      chk("to_cycles", 32'(n), 1024);
      chk("to_done",   32'(bus.done_o), 1);
      chk("to_err",    32'(bus.err_o), 1);
      chk("to_rstlow", 32'(bus.eng_rstn_o), 0);
      chk("to_rsthi_before", 32'(last_rstn), 1);
      chk("to_no_we",  32'(seen_we), 0);
      bus.req_i = 2'b00;
      @(negedge clk);
      bus.req_i = 2'b01;
      run_job("after_to", 5, 2'b01, 2, 2, 15, 12);
      bus.req_i = 2'b00;
      @(negedge clk);

      // Asynchronous reset in the middle of RUN.
      bus.req_i = 2'b01;
      n = 0;
      while (bus.eng_rstn_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("mr_engrst", 32'(bus.eng_rstn_o), 0);
      chk("mr_busy",   32'(bus.busy_o), 0);
      chk("mr_done",   32'(bus.done_o), 0);
      chk("mr_zsel",   32'(bus.z_sel_o), 0);
      chk("mr_wsel",   32'(bus.w_sel_o), 0);
      chk("mr_osel",   32'(bus.out_sel_o), 0);
      bus.req_i = 2'b00;
      @(negedge clk);
      rstn      = 1'b1;
      seen_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done_o !== 2'b00 || bus.busy_o !== 1'b0) seen_done = 1'b1;
      end
      chk("mr_quiet", 32'(seen_done), 0);
      set_req(1, 2, 3, 0);
      bus.req_i = 2'b10;
      run_job("post_rst", 3, 2'b10, 0, 1, 3, 4);
      bus.req_i = 2'b00;
      @(negedge clk);
      chk("end_idle", 32'(bus.busy_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
